// File: rtl/bo_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bo_job_arbiter
// Description : Round-robin arbiter/sequencer sharing one compute unit among
//               N requesters. Optional abort-on-timeout via BO_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bo_job_arbiter #(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] operand,
    output logic [N-1:0]       ack,
    output logic [WIDTH-1:0]   result,
    output logic               err,
    output logic               busy,
    output logic [WIDTH-1:0]   unit_a,
    output logic               unit_start,
    input  logic               unit_done,
    input  logic [WIDTH-1:0]   unit_result
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW:0] c_N = (IW + 1)'(N);

    if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_param_check
        $error("bo_job_arbiter: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_BUSY    = 3'd3,
        S_DELIVER = 3'd4
    } state_t;

    state_t           r_state, w_next;
    logic [IW-1:0]    r_ptr, r_gidx;
    logic [WIDTH-1:0] r_unit_a, r_result;
    logic [N-1:0]     r_ack;
    logic             w_timeout;

    logic [2*N-1:0]   w_dbl;
    logic [N-1:0]     w_rot;
    logic [IW-1:0]    w_off, w_sel;
    logic [IW:0]      w_sum;
    logic             w_found;
    logic [WIDTH-1:0] w_opnd;
    logic [N-1:0]     w_onehot;

    // Rotate requests so that bit 0 is the requester at ptr, then take the lowest set bit.
    always_comb begin
        w_dbl   = {req, req} >> r_ptr;
        w_rot   = w_dbl[N-1:0];
        w_off   = '0;
        w_found = |w_rot;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = IW'(k);
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        w_sel = (w_sum >= c_N) ? IW'(w_sum - c_N) : w_sum[IW-1:0];
    end

    always_comb begin
        w_opnd   = '0;
        w_onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (w_sel == IW'(k)) w_opnd = operand[k*WIDTH +: WIDTH];
            w_onehot[k] = (r_gidx == IW'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_found) w_next = S_LOAD;
            S_LOAD:    w_next = S_START;
            S_START:   w_next = S_BUSY;
            S_BUSY:    if (unit_done || w_timeout) w_next = S_DELIVER;
            S_DELIVER: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // ack/result are loaded on the BUSY exit so they are valid exactly during DELIVER.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_gidx   <= '0;
            r_unit_a <= '0;
            r_result <= '0;
            r_ack    <= '0;
        end else begin
            r_ack    <= '0;
            r_result <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gidx   <= w_sel;
                        r_unit_a <= w_opnd;
                    end
                end
                S_BUSY: begin
                    if (unit_done) begin
                        r_ack    <= w_onehot;
                        r_result <= unit_result;
                    end else if (w_timeout) begin
                        r_ack    <= w_onehot;
                        r_result <= '1;
                    end
                end
                S_DELIVER: begin
                    r_ptr <= (r_gidx == IW'(N - 1)) ? '0 : r_gidx + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef BO_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] r_cnt;
    logic          r_err;

    always_ff @(posedge clk) begin
        if (rst)                       r_cnt <= '0;
        else if (r_state == S_START)   r_cnt <= '0;
        else if (r_state == S_BUSY)    r_cnt <= r_cnt + 1'b1;
    end

    // Last permitted BUSY cycle is the one in which the count reaches TIMEOUT.
    assign w_timeout = (r_state == S_BUSY) && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= w_timeout && !unit_done;
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign ack        = r_ack;
    assign result     = r_result;
    assign busy       = (r_state != S_IDLE);
    assign unit_a     = r_unit_a;
    assign unit_start = (r_state == S_START);

endmodule
`default_nettype wire
